// File: rtl/edge_event_recorder.sv
// Purpose : multi-channel edge recorder. It synchronises the inputs, detects rising and falling
//           edges per channel, and queues {wrap, rise, fall, ts} words in a show-ahead FIFO.
// Latency : an input change settled before edge k is written at edge k+2. rd_valid rises after edge k+2.
// Backpr. : rd_valid/rd_en pop handshake. If the FIFO is full and no pop happens, the event is
//           dropped and the sticky overflow flag is set.
// Ports   : clk, rst_n (async active-low); in_data/chan_en (CH bits); mode (bit0 rise, bit1 fall);
//           enable (run timestamp and record); clear (synchronous flush); rd_en/rd_valid/rd_data
//           (FIFO head); level (stored word count); overflow (sticky drop flag).
module edge_event_recorder #(
  parameter int CH    = 4,
  parameter int TS_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CH-1:0]                in_data,
  input  logic [CH-1:0]                chan_en,
  input  logic [1:0]                   mode,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [2*CH+TS_W:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);
  localparam int W  = 1 + 2*CH + TS_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [CH-1:0]   s1, s2, prev;
  logic [TS_W-1:0] ts;
  logic            wrap_pending;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [W-1:0]    mem [DEPTH];

  logic [CH-1:0]   rise, fall;
  logic            evt, full, pop, wr, drop, ts_wrap;

  // The synchroniser and prev always track the inputs. Edges seen while disabled are therefore
  // consumed and never reported later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_data;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise     = s2 & ~prev & chan_en & {CH{mode[0]}};
  assign fall     = ~s2 & prev & chan_en & {CH{mode[1]}};
  assign evt      = enable & |(rise | fall);

  assign rd_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign pop      = rd_en & rd_valid;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the new word.
  assign wr       = evt & (~full | pop);
  assign drop     = evt & full & ~pop;
  assign ts_wrap  = enable & (ts == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts           <= '0;
      wrap_pending <= 1'b0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
    end else if (clear) begin
      ts           <= '0;
      wrap_pending <= 1'b0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
    end else begin
      if (enable) ts <= ts + TS_W'(1);
      // A wrap wins over a write in the same cycle. The written word carries the old flag, and the
      // new wrap stays pending for the next word.
      if (ts_wrap)   wrap_pending <= 1'b1;
      else if (wr)   wrap_pending <= 1'b0;
      if (drop)      overflow     <= 1'b1;
      if (wr)        wr_ptr       <= wr_ptr + AW'(1);
      if (pop)       rd_ptr       <= rd_ptr + AW'(1);
      if (wr && !pop)      level <= level + LW'(1);
      else if (!wr && pop) level <= level - LW'(1);
    end
  end

  // Storage has no reset. Readers only see it through rd_valid gating.
  always_ff @(posedge clk) begin
    if (wr && !clear) mem[wr_ptr] <= {wrap_pending, rise, fall, ts};
  end

  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_edge_event_recorder.sv
// Purpose : directed self-checking bench for edge_event_recorder (CH=4, TS_W=8, DEPTH=8).
// Latency : inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Backpr. : rd_en is driven directly by the bench steps.
module tb_edge_event_recorder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_data, chan_en;
  logic [1:0]  mode;
  logic        enable, clear, rd_en;
  logic        rd_valid;
  logic [16:0] rd_data;
  logic [3:0]  level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  edge_event_recorder #(.CH(4), .TS_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .chan_en(chan_en), .mode(mode),
    .enable(enable), .clear(clear), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] word(input logic w, input logic [3:0] r,
                                       input logic [3:0] f, input logic [7:0] t);
    return {w, r, f, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // One clear cycle. The timestamp reads 0 during the following cycle.
  task automatic restart();
    clear = 1'b1;
    rd_en = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_data = 4'h0; chan_en = 4'hF; mode = 2'b11;
    enable = 1'b0; clear = 1'b0; rd_en = 1'b0;
    tick_n(3);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data",  32'(rd_data),  32'd0);
    check("reset_level",    32'(level),    32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    // First event latency: the change before edge 5 (ts=4) is written at edge 7 with ts=6.
    rst_n = 1'b1; enable = 1'b1;
    tick_n(4);
    in_data = 4'b0001;
    tick_n(2);
    check("lat_not_yet", 32'(rd_valid), 32'd0);
    tick();
    check("lat_valid", 32'(rd_valid), 32'd1);
    check("lat_level", 32'(level), 32'd1);
    check("lat_word",  32'(rd_data), 32'(word(1'b0, 4'b0001, 4'b0000, 8'd6)));
    pop1();
    check("pop_empty_data", 32'(rd_data), 32'd0);

    // ch0 rises and ch2 falls in the same cycle.
    in_data = 4'b0100;
    tick_n(3);
    restart();
    in_data = 4'b0001;
    tick_n(3);
    check("both_level", 32'(level), 32'd1);
    check("both_word", 32'(rd_data), 32'(word(1'b0, 4'b0001, 4'b0100, 8'd2)));
    pop1();
    mode = 2'b00; in_data = 4'b0100;
    tick_n(3);
    check("mode00_none", 32'(level), 32'd0);
    restart();
    mode = 2'b01; in_data = 4'b0001;
    tick_n(3);
    check("mode01_word", 32'(rd_data), 32'(word(1'b0, 4'b0001, 4'b0000, 8'd2)));
    pop1();
    mode = 2'b11;

    // Channel-enable masking.
    restart();
    chan_en = 4'b1110; in_data = 4'b0000;
    tick_n(3);
    check("chan_en_ch0_masked", 32'(level), 32'd0);
    in_data = 4'b0011;
    tick_n(3);
    check("chan_en_word", 32'(rd_data), 32'(word(1'b0, 4'b0010, 4'b0000, 8'd5)));
    pop1();
    chan_en = 4'hF;

    // Wrap flag after 256 quiet cycles.
    restart();
    tick_n(256);
    in_data = 4'b0111;
    tick_n(3);
    check("wrap_word1", 32'(rd_data), 32'(word(1'b1, 4'b0100, 4'b0000, 8'd2)));
    in_data = 4'b1111;
    tick_n(3);
    check("wrap_level2", 32'(level), 32'd2);
    pop1();
    check("wrap_word2", 32'(rd_data), 32'(word(1'b0, 4'b1000, 4'b0000, 8'd5)));
    pop1();

    // A write on the wrapping cycle carries wrap=0 and leaves the wrap pending for the next word.
    restart();
    tick_n(253);
    in_data = 4'b1110;
    tick_n(3);
    check("wrapwr_word1", 32'(rd_data), 32'(word(1'b0, 4'b0000, 4'b0001, 8'd255)));
    in_data = 4'b1100;
    tick_n(3);
    pop1();
    check("wrapwr_word2", 32'(rd_data), 32'(word(1'b1, 4'b0000, 4'b0010, 8'd2)));
    pop1();

    // Ten events, no reads: eight are stored and the rest are dropped.
    restart();
    for (int i = 0; i < 10; i++) begin
      in_data[0] = ~in_data[0];
      tick();
    end
    check("ovf_full_level", 32'(level), 32'd8);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    tick();
    check("ovf_set", 32'(overflow), 32'd1);
    tick();
    check("ovf_level", 32'(level), 32'd8);
    rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf_pop%0d", k), 32'(rd_data),
            32'(word(1'b0, (k % 2 == 0) ? 4'b0001 : 4'b0000,
                     (k % 2 == 0) ? 4'b0000 : 4'b0001, 8'(2 + k))));
      tick();
    end
    rd_en = 1'b0;
    check("ovf_drained", 32'(level), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // When full, a simultaneous pop and write keep the level at 8 with no overflow.
    restart();
    for (int i = 0; i < 8; i++) begin
      in_data[0] = ~in_data[0];
      tick();
    end
    tick_n(2);
    check("fp_level8", 32'(level), 32'd8);
    in_data[0] = ~in_data[0];
    tick_n(2);
    pop1();
    check("fp_level", 32'(level), 32'd8);
    check("fp_no_ovf", 32'(overflow), 32'd0);
    check("fp_head", 32'(rd_data), 32'(word(1'b0, 4'b0000, 4'b0001, 8'd3)));
    for (int i = 0; i < 7; i++) pop1();
    check("fp_tail", 32'(rd_data), 32'(word(1'b0, 4'b0001, 4'b0000, 8'd12)));
    pop1();
    check("fp_empty", 32'(level), 32'd0);

    // Clear beats a concurrent event and pop.
    for (int i = 0; i < 9; i++) begin
      in_data[0] = ~in_data[0];
      tick();
    end
    tick_n(2);
    check("clr_ovf_before", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) pop1();
    check("clr_level3", 32'(level), 32'd3);
    in_data[0] = ~in_data[0];
    tick_n(2);
    clear = 1'b1; rd_en = 1'b1;
    tick();
    clear = 1'b0; rd_en = 1'b0;
    check("clr_level", 32'(level), 32'd0);
    check("clr_valid", 32'(rd_valid), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_data", 32'(rd_data), 32'd0);
    in_data[0] = ~in_data[0];
    tick_n(3);
    check("clr_ts_restart", 32'(rd_data), 32'(word(1'b0, 4'b0000, 4'b0001, 8'd2)));

    // Reset asserted mid-operation, then resynchronise: in_data=1100 is seen as rises on ch2 and ch3.
    #2 rst_n = 1'b0;
    #1;
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_valid", 32'(rd_valid), 32'd0);
    check("mrst_data", 32'(rd_data), 32'd0);
    #1 rst_n = 1'b1;
    tick_n(2);
    check("mrst_no_early", 32'(level), 32'd0);
    tick();
    check("mrst_word", 32'(rd_data), 32'(word(1'b0, 4'b1100, 4'b0000, 8'd2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
